fgen_sweep_ctrl: RTL

- Sequencer that drives the waveform-select and delta (rate divider) inputs of the function generator to perform frequency sweeps.
- Steps delta from a start value to a stop value by a fixed increment. Holds each step for a programmed number of complete waveform periods, counted by observing the generator's 12-bit output.
- Sits between the host/config registers and the function generator; it is the only writer of the generator's sel/delta.

---
 rtl/fgen_sweep_ctrl_pkg.sv | 29 ++
 rtl/fgen_sweep_ctrl_period_detect.sv | 31 +++
 rtl/fgen_sweep_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fgen_sweep_ctrl_pkg.sv
// Shared types and defaults for the function-generator sweep sequencer.
// Holds the FSM state enum, waveform encodings and default widths.
package PKG_FgenSweep;

  localparam int DELTA_W_DEF = 8;
  localparam int DWELL_W_DEF = 16;
  localparam int OUT_W_DEF   = 12;

  // Same encodings as the generator's own waveform type.
  typedef enum logic [1:0] {
    SAWTOOTH = 2'd0,
    TRIANGLE = 2'd1,
    SINE     = 2'd2
  } wave_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL = 2'd2,
    STEP  = 2'd3
  } state_t;

  // Code 3 has no waveform of its own; fold it onto sawtooth.
  function automatic wave_t wave_norm(input logic [1:0] s);
    if (s == 2'd3) return SAWTOOTH;
    return wave_t'(s);
  endfunction

endpackage

// File: rtl/fgen_sweep_ctrl_period_detect.sv
// Period-boundary detector: one-cycle pulse when the observed output
// falls to zero. Ports: clk, rst_n, i_clear, i_out, o_boundary.
module fgen_period_detect #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic [OUT_W-1:0] i_out,
  output logic             o_boundary
);

  logic [OUT_W-1:0] r_prev;

  // Clearing forces the history to zero so a zero that was already
  // present at the clear point is not mistaken for a fresh boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
    end else if (i_clear) begin
      r_prev <= '0;
    end else begin
      r_prev <= i_out;
    end
  end

  assign o_boundary = !i_clear
                    && (i_out == '0)
                    && (r_prev != '0);

endmodule

// File: rtl/fgen_sweep_ctrl.sv
// Frequency-sweep sequencer driving the function generator sel/delta.
// Ports: clk, rst_n, start, abort, cfg_*, fg_out in; fg_sel, fg_delta,
// busy, done, step_idx out. Macro FGEN_SWEEP_PINGPONG_EN: bounce
// between endpoints until abort instead of a single pass.
module fgen_sweep_ctrl
  import PKG_FgenSweep::*;
#(
  parameter int DELTA_W = DELTA_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         cfg_sel,
  input  logic [DELTA_W-1:0] cfg_delta_start,
  input  logic [DELTA_W-1:0] cfg_delta_stop,
  input  logic [DELTA_W-1:0] cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [OUT_W-1:0]   fg_out,
  output logic [1:0]         fg_sel,
  output logic [DELTA_W-1:0] fg_delta,
  output logic               busy,
  output logic               done,
  output logic [DELTA_W-1:0] step_idx
);

  localparam logic [DELTA_W-1:0] D_ONE =
    {{(DELTA_W-1){1'b0}}, 1'b1};
  localparam logic [DWELL_W:0] W_ONE =
    {{DWELL_W{1'b0}}, 1'b1};

  state_t r_state;
  state_t w_state_nxt;

  wave_t              r_sh_sel;
  logic [DELTA_W-1:0] r_sh_start;
  logic [DELTA_W-1:0] r_sh_stop;
  logic [DELTA_W-1:0] r_sh_step;
  logic [DWELL_W-1:0] r_sh_dwell;
  logic               r_up;

  logic [DWELL_W-1:0] r_dwell_cnt;
  logic [1:0]         r_fg_sel;
  logic [DELTA_W-1:0] r_fg_delta;
  logic               r_busy;
  logic [DELTA_W-1:0] r_step_idx;

  logic               w_bnd;
  logic               w_clear;
  logic [DWELL_W:0]   w_cnt_inc;
  logic               w_dwell_hit;
  logic [DELTA_W:0]   w_sum;
  logic [DELTA_W:0]   w_dif;
  logic [DELTA_W-1:0] w_next;
  logic               w_last;
  logic               w_accept;
  logic               w_hold;
  logic               w_done;

`ifdef FGEN_SWEEP_PINGPONG_EN
  logic               r_hold;
  logic [DELTA_W-1:0] w_rnext;
  logic               w_rlast;
`endif

  assign w_clear = (r_state == LOAD);

  fgen_period_detect #(
    .OUT_W(OUT_W)
  ) u_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_out     (fg_out),
    .o_boundary(w_bnd)
  );

  assign w_accept = start && !abort;

  assign w_cnt_inc   = {1'b0, r_dwell_cnt} + W_ONE;
  assign w_dwell_hit = w_bnd
                     && (w_cnt_inc >= {1'b0, r_sh_dwell});

  // Step arithmetic carries one extra bit so overshoot past the
  // top of the range and borrow below zero are both visible.
  always_comb begin
    w_sum  = {1'b0, r_fg_delta} + {1'b0, r_sh_step};
    w_dif  = {1'b0, r_fg_delta} - {1'b0, r_sh_step};
    w_next = r_up ? w_sum[DELTA_W-1:0]
                  : w_dif[DELTA_W-1:0];
    w_last = 1'b0;
    if (r_sh_step == '0)
      w_last = 1'b1;
    else if (r_fg_delta == r_sh_stop)
      w_last = 1'b1;
    else if (r_up)
      w_last = (w_sum > {1'b0, r_sh_stop});
    else
      w_last = w_dif[DELTA_W]
            || (w_dif[DELTA_W-1:0] < r_sh_stop);
  end

`ifdef FGEN_SWEEP_PINGPONG_EN
  // Move away from the endpoint just reached, towards the old start.
  always_comb begin
    w_rnext = r_up ? w_dif[DELTA_W-1:0]
                   : w_sum[DELTA_W-1:0];
    w_rlast = 1'b0;
    if (r_sh_step == '0)
      w_rlast = 1'b1;
    else if (r_fg_delta == r_sh_start)
      w_rlast = 1'b1;
    else if (r_up)
      w_rlast = w_dif[DELTA_W]
             || (w_dif[DELTA_W-1:0] < r_sh_start);
    else
      w_rlast = (w_sum > {1'b0, r_sh_start});
  end
  assign w_hold = r_hold;
`else
  assign w_hold = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_accept) w_state_nxt = LOAD;
      LOAD:  w_state_nxt = DWELL;
      DWELL: if (w_dwell_hit && !w_hold)
               w_state_nxt = STEP;
      STEP: begin
`ifdef FGEN_SWEEP_PINGPONG_EN
        w_state_nxt = DWELL;
`else
        w_state_nxt = w_last ? IDLE : DWELL;
`endif
      end
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // Outputs
  always_comb begin
    w_done = (r_state == STEP) && w_last && !abort;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_sel    <= SAWTOOTH;
      r_sh_start  <= '0;
      r_sh_stop   <= '0;
      r_sh_step   <= '0;
      r_sh_dwell  <= '0;
      r_up        <= 1'b0;
      r_dwell_cnt <= '0;
      r_fg_sel    <= '0;
      r_fg_delta  <= '0;
      r_busy      <= 1'b0;
      r_step_idx  <= '0;
`ifdef FGEN_SWEEP_PINGPONG_EN
      r_hold      <= 1'b0;
`endif
    end else begin
      r_busy <= (w_state_nxt != IDLE);
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sh_sel   <= wave_norm(cfg_sel);
            r_sh_start <= cfg_delta_start;
            r_sh_stop  <= cfg_delta_stop;
            r_sh_step  <= cfg_step;
            r_sh_dwell <= (cfg_dwell == '0)
                        ? {{(DWELL_W-1){1'b0}}, 1'b1}
                        : cfg_dwell;
            r_up <= (cfg_delta_start <= cfg_delta_stop);
          end
        end
        LOAD: begin
          if (!abort) begin
            r_fg_sel    <= r_sh_sel;
            r_fg_delta  <= r_sh_start;
            r_dwell_cnt <= '0;
            r_step_idx  <= '0;
`ifdef FGEN_SWEEP_PINGPONG_EN
            r_hold      <= 1'b0;
`endif
          end
        end
        DWELL: begin
          if (!abort && w_bnd)
            r_dwell_cnt <= w_cnt_inc[DWELL_W-1:0];
        end
        STEP: begin
          if (!abort) begin
            r_dwell_cnt <= '0;
            if (r_step_idx != '1)
              r_step_idx <= r_step_idx + D_ONE;
`ifdef FGEN_SWEEP_PINGPONG_EN
            if (!w_last) begin
              r_fg_delta <= w_next;
            end else begin
              // Endpoint reached: reverse and swap the bounds.
              r_up       <= !r_up;
              r_sh_start <= r_sh_stop;
              r_sh_stop  <= r_sh_start;
              if (w_rlast) r_hold     <= 1'b1;
              else         r_fg_delta <= w_rnext;
            end
`else
            if (!w_last) r_fg_delta <= w_next;
`endif
          end
        end
      endcase
    end
  end

  assign fg_sel   = r_fg_sel;
  assign fg_delta = r_fg_delta;
  assign busy     = r_busy;
  assign done     = w_done;
  assign step_idx = r_step_idx;

endmodule
